joypad_scanner: RTL and testbench

- Parametrised successor to the single-pad controller block: one clock domain, any number of NES/SNES-style serial pads, configurable shift length, integrated latch/pulse generator, debounce, and hardware-accurate P1 (0xFF00) readback.
- Sits on the IO register bus beside the other IO-register peripherals.
- Raises the joypad interrupt toward the CPU interrupt controller.

---
 rtl/joypad_scanner_pkg.sv | 21 ++
 rtl/joypad_scanner_pad_shift_engine.sv | 70 +++++++
 rtl/joypad_scanner.sv | 63 ++++++
 tb/tb_joypad_scanner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/joypad_scanner_pkg.sv
// joypad_scanner_pkg: shared P1 address, button/pad bit maps and scan FSM states.
package joypad_scanner_pkg;
    localparam logic [15:0] P1_ADDR = 16'hFF00;
    localparam int BTN_RIGHT = 0, BTN_LEFT = 1, BTN_UP = 2, BTN_DOWN = 3;
    localparam int BTN_A = 4, BTN_B = 5, BTN_SELECT = 6, BTN_START = 7;
    localparam int PAD_A = 0, PAD_B = 1, PAD_SELECT = 2, PAD_START = 3;
    localparam int PAD_UP = 4, PAD_DOWN = 5, PAD_LEFT = 6, PAD_RIGHT = 7;
    typedef enum logic [2:0] {ST_IDLE, ST_LATCH, ST_SHIFT_LO, ST_SHIFT_HI, ST_UPDATE} scan_state_t;
    function automatic logic [7:0] pad_to_buttons(input logic [7:0] p);
        logic [7:0] b;
        b[BTN_RIGHT]  = p[PAD_RIGHT];
        b[BTN_LEFT]   = p[PAD_LEFT];
        b[BTN_UP]     = p[PAD_UP];
        b[BTN_DOWN]   = p[PAD_DOWN];
        b[BTN_A]      = p[PAD_A];
        b[BTN_B]      = p[PAD_B];
        b[BTN_SELECT] = p[PAD_SELECT];
        b[BTN_START]  = p[PAD_START];
        return b;
    endfunction
endpackage

// File: rtl/joypad_scanner_pad_shift_engine.sv
// pad_shift_engine: poll timer, latch/pulse generator and serial capture of all pads.
module pad_shift_engine
    import joypad_scanner_pkg::*;
#(
    parameter int NUM_PADS    = 1,
    parameter int NUM_BITS    = 8,
    parameter int HALF_PERIOD = 16,
    parameter int POLL_CYCLES = 65536
) (
    input  logic                I_CLK,
    input  logic                I_RESET_L,
    input  logic [NUM_PADS-1:0] I_PAD_DATA,
    output logic                O_PAD_LATCH,
    output logic                O_PAD_PULSE,
    output logic [7:0]          O_RAW,
    output logic                O_SCAN_DONE
);
    localparam int PW = $clog2(POLL_CYCLES);
    localparam int TW = $clog2(2 * HALF_PERIOD);
    localparam int IW = $clog2(NUM_BITS);
    scan_state_t r_state, w_next;
    logic [PW-1:0] r_poll;
    logic [TW-1:0] r_tmr;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_raw;
    logic          w_wrap, w_tmr_end, w_last;
    assign w_wrap    = r_poll == PW'(POLL_CYCLES - 1);
    assign w_tmr_end = r_tmr == TW'(r_state == ST_LATCH ? 2 * HALF_PERIOD - 1 : HALF_PERIOD - 1);
    assign w_last    = r_idx == IW'(NUM_BITS - 1);
    assign O_RAW     = r_raw;
    always_ff @(posedge I_CLK or negedge I_RESET_L)
        if (!I_RESET_L) r_state <= ST_IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next      = r_state;
        O_PAD_LATCH = 1'b0;
        O_PAD_PULSE = 1'b0;
        O_SCAN_DONE = 1'b0;
        case (r_state)
            ST_IDLE:     w_next = w_wrap ? ST_LATCH : ST_IDLE;
            ST_LATCH: begin
                O_PAD_LATCH = 1'b1;
                w_next = w_tmr_end ? ST_SHIFT_LO : ST_LATCH;
            end
            ST_SHIFT_LO: w_next = !w_tmr_end ? ST_SHIFT_LO : w_last ? ST_UPDATE : ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                O_PAD_PULSE = 1'b1;
                w_next = w_tmr_end ? ST_SHIFT_LO : ST_SHIFT_HI;
            end
            default: begin
                O_SCAN_DONE = 1'b1;
                w_next = ST_IDLE;
            end
        endcase
    end
    // Poll counter runs free so scan starts stay exactly POLL_CYCLES apart.
    always_ff @(posedge I_CLK or negedge I_RESET_L)
        if (!I_RESET_L) begin
            r_poll <= '0;
            r_tmr  <= '0;
            r_idx  <= '0;
            r_raw  <= '0;
        end else begin
            r_poll <= w_wrap ? '0 : r_poll + 1'b1;
            r_tmr  <= (r_state == ST_IDLE || w_tmr_end) ? '0 : r_tmr + 1'b1;
            if (r_state == ST_LATCH) r_idx <= '0;
            else if (r_state == ST_SHIFT_HI && w_tmr_end) r_idx <= r_idx + 1'b1;
            if (r_state == ST_SHIFT_LO && w_tmr_end && int'(r_idx) < 8) r_raw[r_idx[2:0]] <= ~&I_PAD_DATA;
        end
endmodule

// File: rtl/joypad_scanner.sv
// joypad_scanner: multi-pad serial scanner with debounce, P1 (0xFF00) readback and joypad interrupt.
module joypad_scanner
    import joypad_scanner_pkg::*;
#(
    parameter int NUM_PADS    = 1,
    parameter int NUM_BITS    = 8,
    parameter int HALF_PERIOD = 16,
    parameter int POLL_CYCLES = 65536,
    parameter int DEBOUNCE    = 2
) (
    input  logic                I_CLK,
    input  logic                I_RESET_L,
    input  logic [15:0]         I_IOREG_ADDR,
    inout  wire  [7:0]          IO_IOREG_DATA,
    input  logic                I_IOREG_WE_L,
    input  logic                I_IOREG_RE_L,
    output logic                O_PAD_LATCH,
    output logic                O_PAD_PULSE,
    input  logic [NUM_PADS-1:0] I_PAD_DATA,
    output logic [7:0]          O_BUTTONS,
    output logic                O_CONTROLLER_INTERRUPT
);
    localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
    logic [7:0]    w_raw_pad, w_raw;
    logic          w_scan_done, w_p1_hit;
    logic [3:0]    w_low, r_low_d;
    logic [1:0]    r_sel;
    logic [7:0]    r_buttons;
    logic [CW-1:0] r_cnt [8];
    logic          r_int;
    pad_shift_engine #(
        .NUM_PADS(NUM_PADS), .NUM_BITS(NUM_BITS), .HALF_PERIOD(HALF_PERIOD), .POLL_CYCLES(POLL_CYCLES)
    ) u_engine (
        .I_CLK(I_CLK), .I_RESET_L(I_RESET_L), .I_PAD_DATA(I_PAD_DATA),
        .O_PAD_LATCH(O_PAD_LATCH), .O_PAD_PULSE(O_PAD_PULSE), .O_RAW(w_raw_pad), .O_SCAN_DONE(w_scan_done)
    );
    assign w_raw    = pad_to_buttons(w_raw_pad);
    assign w_low    = ~(({4{~r_sel[0]}} & r_buttons[3:0]) | ({4{~r_sel[1]}} & r_buttons[7:4]));
    assign w_p1_hit = I_IOREG_ADDR == P1_ADDR;
    assign IO_IOREG_DATA = (w_p1_hit && !I_IOREG_RE_L) ? {2'b11, r_sel, w_low} : 8'hzz;
    assign O_BUTTONS = r_buttons;
    assign O_CONTROLLER_INTERRUPT = r_int;
    // A button's counter only advances on scans that disagree with the accepted state.
    always_ff @(posedge I_CLK or negedge I_RESET_L)
        if (!I_RESET_L) begin
            r_sel     <= 2'b11;
            r_low_d   <= 4'hF;
            r_int     <= 1'b0;
            r_buttons <= '0;
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
        end else begin
            if (w_p1_hit && !I_IOREG_WE_L) r_sel <= IO_IOREG_DATA[5:4];
            r_low_d <= w_low;
            r_int   <= |(r_low_d & ~w_low);
            if (w_scan_done)
                for (int i = 0; i < 8; i++)
                    if (w_raw[i] == r_buttons[i]) r_cnt[i] <= '0;
                    else if (r_cnt[i] == CW'(DEBOUNCE - 1)) begin
                        r_buttons[i] <= w_raw[i];
                        r_cnt[i]     <= '0;
                    end else r_cnt[i] <= r_cnt[i] + 1'b1;
        end
endmodule

// File: tb/tb_joypad_scanner.sv
// tb_joypad_scanner: scoreboard bench driving two serial pads against a scan-level reference model.
module tb_joypad_scanner;
    localparam int NUM_PADS = 2, NUM_BITS = 16, HALF = 2, POLL = 512, DEB = 2;
    localparam int BTN_POS [8] = '{4, 5, 6, 7, 2, 3, 1, 0};
    typedef struct {logic [15:0] p0; logic [15:0] p1; logic we; logic [7:0] wd;} step_t;

    logic clk = 0, rst_n = 0, we_l = 1, re_l = 1, drv_en = 0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  drv_data = 8'h00;
    wire  [7:0]  data;
    logic latch, pulse, irq;
    logic [NUM_PADS-1:0] pad_data;
    logic [7:0] buttons;
    logic [15:0] cur_w0 = 16'h0, cur_w1 = 16'h0;
    logic [4:0] pad_idx = 0;
    logic prev_pulse = 0;

    int n_cmp = 0, n_mis = 0, irq_cnt = 0, exp_irq = 0;
    logic mon_en = 1;
    logic [7:0] m_btn = 8'h00;
    logic [1:0] m_sel = 2'b11;
    logic [7:0] m_hist [$];
    logic [7:0] btn_q [$];
    logic [7:0] rd_q [$];
    step_t steps [$];

    assign data = drv_en ? drv_data : 8'hzz;
    assign pad_data[0] = ~cur_w0[pad_idx[3:0]];
    assign pad_data[1] = ~cur_w1[pad_idx[3:0]];

    joypad_scanner #(.NUM_PADS(NUM_PADS), .NUM_BITS(NUM_BITS), .HALF_PERIOD(HALF), .POLL_CYCLES(POLL), .DEBOUNCE(DEB)) dut (
        .I_CLK(clk), .I_RESET_L(rst_n), .I_IOREG_ADDR(addr), .IO_IOREG_DATA(data),
        .I_IOREG_WE_L(we_l), .I_IOREG_RE_L(re_l), .O_PAD_LATCH(latch), .O_PAD_PULSE(pulse),
        .I_PAD_DATA(pad_data), .O_BUTTONS(buttons), .O_CONTROLLER_INTERRUPT(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] vis_low(input logic [7:0] b, input logic [1:0] s);
        logic [3:0] v = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (!s[0] && b[i]) v[i] = 1'b0;
            if (!s[1] && b[i+4]) v[i] = 1'b0;
        end
        return v;
    endfunction

    // Reference: a button flips once DEB consecutive scans all disagree with it.
    task automatic model_scan(input logic [15:0] w0, input logic [15:0] w1);
        logic [7:0] raw = 8'h00;
        logic [7:0] nb;
        for (int j = 0; j < 8; j++) if (w0[j] | w1[j]) raw[BTN_POS[j]] = 1'b1;
        m_hist.push_back(raw);
        nb = m_btn;
        for (int b = 0; b < 8; b++) begin
            int dis = 0;
            for (int k = 0; k < DEB && k < m_hist.size(); k++)
                if (m_hist[m_hist.size() - 1 - k][b] != m_btn[b]) dis++;
            if (dis == DEB) nb[b] = ~m_btn[b];
        end
        if (|(vis_low(m_btn, m_sel) & ~vis_low(nb, m_sel))) exp_irq++;
        m_btn = nb;
    endtask

    task automatic p1_write(input logic [7:0] d);
        @(posedge clk); #1;
        addr = 16'hFF00; drv_data = d; drv_en = 1; we_l = 0;
        @(posedge clk); #1;
        we_l = 1; drv_en = 0; addr = 16'h0000;
        if (|(vis_low(m_btn, m_sel) & ~vis_low(m_btn, d[5:4]))) exp_irq++;
        m_sel = d[5:4];
    endtask

    task automatic p1_read();
        @(posedge clk); #1;
        addr = 16'hFF00; re_l = 0;
        rd_q.push_back({2'b11, m_sel, vis_low(m_btn, m_sel)});
        @(posedge clk); #1;
        re_l = 1; addr = 16'h0000;
    endtask

    // Pad shift register: reloads on latch, advances on each rising pulse.
    always @(negedge clk) begin
        if (latch) pad_idx <= 0;
        else if (pulse && !prev_pulse) pad_idx <= pad_idx + 1;
        prev_pulse <= pulse;
        if (irq) irq_cnt++;
    end

    always @(negedge clk)
        if (!re_l && addr == 16'hFF00) begin
            if (rd_q.size() == 0) begin
                n_cmp++; n_mis++;
                $display("FAIL p1_read: got 0x%0h, expected no read pending", data);
            end else check("p1_read", int'(data), int'(rd_q.pop_front()));
        end

    initial begin : scan_monitor
        forever begin
            @(posedge latch);
            if (mon_en) begin
                repeat (NUM_BITS - 1) @(negedge pulse);
                repeat (HALF + 2) @(negedge clk);
                if (btn_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL buttons: got 0x%0h, expected no scan pending", buttons);
                end else check("buttons", int'(buttons), int'(btn_q.pop_front()));
            end
        end
    end

    int lat_w = 0, pul_w = 0, npul = 0;
    logic seen = 0;
    always @(negedge clk)
        if (!mon_en || !rst_n) begin
            lat_w = 0; pul_w = 0; npul = 0; seen = 0;
        end else begin
            if (latch && lat_w == 0) begin
                if (seen) check("pulses_per_scan", npul, NUM_BITS - 1);
                npul = 0; seen = 1;
            end
            if (latch) lat_w++;
            else if (lat_w != 0) begin check("latch_width", lat_w, 2 * HALF); lat_w = 0; end
            if (pulse) pul_w++;
            else if (pul_w != 0) begin check("pulse_width", pul_w, HALF); pul_w = 0; npul++; end
        end

    initial begin : watchdog
        #1_000_000;
        n_mis++;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin : stimulus
        int lat;
        step_t st;
        steps.push_back('{16'h0000, 16'h0000, 1'b0, 8'h00});
        steps.push_back('{16'h0001, 16'h0000, 1'b0, 8'h00});
        steps.push_back('{16'h0001, 16'h0000, 1'b1, 8'h10});
        steps.push_back('{16'h0022, 16'h0000, 1'b1, 8'h30});
        steps.push_back('{16'h0022, 16'h0000, 1'b1, 8'h20});
        steps.push_back('{16'h0022, 16'h0000, 1'b1, 8'h10});
        steps.push_back('{16'h0022, 16'h0000, 1'b1, 8'h00});
        steps.push_back('{16'h0022, 16'h0000, 1'b1, 8'h30});
        steps.push_back('{16'hFF00, 16'hFF08, 1'b0, 8'h00});
        steps.push_back('{16'hFF00, 16'hFF08, 1'b0, 8'h00});
        steps.push_back('{16'h0080, 16'h0000, 1'b1, 8'h20});
        steps.push_back('{16'h0000, 16'h0000, 1'b0, 8'h00});
        st = '{16'h0000, 16'h0000, 1'b0, 8'h00};
        for (int r = 0; r < 18; r++) begin
            if ($urandom_range(1, 0) == 1) begin
                st.p0 = {8'($urandom), 8'($urandom) & 8'($urandom)};
                st.p1 = {8'($urandom), 8'($urandom) & 8'($urandom) & 8'($urandom)};
            end
            st.we = 1'($urandom);
            st.wd = 8'($urandom);
            steps.push_back(st);
        end
        steps.push_back('{16'h00FF, 16'h0000, 1'b0, 8'h00});
        steps.push_back('{16'h00FF, 16'h0000, 1'b1, 8'h00});

        repeat (3) @(negedge clk);
        check("reset_buttons", int'(buttons), 0);
        check("reset_latch", int'(latch), 0);
        check("reset_pulse", int'(pulse), 0);
        check("reset_irq", int'(irq), 0);
        rst_n = 1;
        for (int s = 0; s < steps.size(); s++) begin
            cur_w0 = steps[s].p0;
            cur_w1 = steps[s].p1;
            model_scan(cur_w0, cur_w1);
            btn_q.push_back(m_btn);
            if (s == 0) begin
                lat = 0;
                while (!latch) begin @(negedge clk); lat++; end
                check("first_scan_start", lat, POLL);
            end else @(posedge latch);
            repeat (80) @(negedge clk);
            if (steps[s].we) p1_write(steps[s].wd);
            p1_read();
            repeat (4) @(negedge clk);
            check("irq_count", irq_cnt, exp_irq);
        end
        check("btn_queue_drained", btn_q.size(), 0);

        mon_en = 0;
        @(posedge latch);
        repeat (4) @(posedge pulse);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("midscan_latch", int'(latch), 0);
        check("midscan_pulse", int'(pulse), 0);
        check("midscan_buttons", int'(buttons), 0);
        m_btn = 8'h00; m_sel = 2'b11; m_hist.delete();
        p1_read();
        @(negedge clk);
        rst_n = 1;
        lat = 0;
        while (!latch) begin @(negedge clk); lat++; end
        check("restart_latency", lat, POLL);
        repeat (80) @(negedge clk);
        check("post_reset_debounce", int'(buttons), 0);
        check("final_irq_count", irq_cnt, exp_irq);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
